// File: rtl/traffic_light_controller_pkg.sv
// Shared types and constants for the two-road traffic light controller.
// Holds the phase enum, the parameter-selector encodings and the lamp patterns.
package traffic_light_controller_pkg;

    typedef enum logic [2:0] {
        MG_A,
        MG_B,
        MY,
        WALK,
        SG_A,
        SG_B,
        SY
    } state_t;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // Lamp order: {walk, main_R, main_Y, main_G, side_R, side_Y, side_G}
    localparam logic [6:0] LED_MAIN_GREEN  = 7'h0C;
    localparam logic [6:0] LED_MAIN_YELLOW = 7'h14;
    localparam logic [6:0] LED_WALK        = 7'h64;
    localparam logic [6:0] LED_SIDE_GREEN  = 7'h21;
    localparam logic [6:0] LED_SIDE_YELLOW = 7'h22;

    function automatic logic [3:0] clampDuration(input logic [3:0] value);
        return (value == 4'd0) ? 4'd1 : value;
    endfunction

endpackage

// File: rtl/traffic_light_controller_tick_divider.sv
// Divides the system clock down to a one-cycle "second" tick.
// With TICKS_PER_SEC = 1 the counter never leaves zero and the tick is always high.
module tick_divider #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int COUNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(TICKS_PER_SEC - 1);

    logic [COUNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (r_count == LAST_COUNT) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST_COUNT);

endmodule

// File: rtl/traffic_light_controller.sv
// Main/side street intersection controller with pedestrian phase, sensor extension
// and runtime-programmable phase durations counted in divider ticks.
module traffic_light_controller
    import traffic_light_controller_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter int DEF_BASE      = 6,
    parameter int DEF_EXT       = 3,
    parameter int DEF_YEL       = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       reprogram,
    input  logic [1:0] time_parameter_selector,
    input  logic [3:0] time_value,
    output logic [6:0] led
);

    state_t     r_state;
    state_t     w_nextState;
    logic [4:0] r_timer;
    logic [4:0] w_nextDuration;
    logic [3:0] r_tBase;
    logic [3:0] r_tExt;
    logic [3:0] r_tYel;
    logic       r_walkLatch;

    logic       w_tick;
    logic       w_phaseDone;
    logic       w_enterWalk;
    logic       w_writeEn;
    logic [3:0] w_progValue;
    logic [3:0] w_restartBase;

    tick_divider #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tickDivider (
        .clock(clock),
        .reset(reset),
        .clear(reprogram),
        .tick (w_tick)
    );

    assign w_progValue   = clampDuration(time_value);
    assign w_writeEn     = reprogram && (time_parameter_selector != SEL_NONE);
    assign w_restartBase = (w_writeEn && (time_parameter_selector == SEL_BASE)) ? w_progValue : r_tBase;
    assign w_phaseDone   = w_tick && (r_timer <= 5'd1);
    // A restart lands in MG_A, so only a genuine phase change into WALK consumes the request.
    assign w_enterWalk   = w_phaseDone && !reprogram && (w_nextState == WALK);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tBase <= 4'(DEF_BASE);
            r_tExt  <= 4'(DEF_EXT);
            r_tYel  <= 4'(DEF_YEL);
        end else if (w_writeEn) begin
            case (time_parameter_selector)
                SEL_BASE: r_tBase <= w_progValue;
                SEL_EXT:  r_tExt  <= w_progValue;
                SEL_YEL:  r_tYel  <= w_progValue;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_walkLatch <= 1'b0;
        end else if (w_enterWalk) begin
            r_walkLatch <= 1'b0;
        end else if (walk_request) begin
            r_walkLatch <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= MG_A;
            r_timer <= {1'b0, 4'(DEF_BASE)};
        end else if (reprogram) begin
            r_state <= MG_A;
            r_timer <= {1'b0, w_restartBase};
        end else if (w_phaseDone) begin
            r_state <= w_nextState;
            r_timer <= w_nextDuration;
        end else if (w_tick) begin
            r_timer <= r_timer - 5'd1;
        end
    end

    // Sensor and walk latch only matter at the exit tick, where this result is used.
    always_comb begin
        w_nextState    = r_state;
        w_nextDuration = {1'b0, r_tBase};
        case (r_state)
            MG_A: begin
                w_nextState    = MG_B;
                w_nextDuration = {1'b0, (sensor ? r_tExt : r_tBase)};
            end
            MG_B: begin
                w_nextState    = MY;
                w_nextDuration = {1'b0, r_tYel};
            end
            MY: begin
                if (r_walkLatch) begin
                    w_nextState    = WALK;
                    w_nextDuration = {1'b0, r_tExt};
                end else begin
                    w_nextState    = SG_A;
                    w_nextDuration = {1'b0, r_tBase};
                end
            end
            WALK: begin
                w_nextState    = SG_A;
                w_nextDuration = {1'b0, r_tBase};
            end
            SG_A: begin
                if (sensor) begin
                    w_nextState    = SG_B;
                    w_nextDuration = {1'b0, r_tExt};
                end else begin
                    w_nextState    = SY;
                    w_nextDuration = {1'b0, r_tYel};
                end
            end
            SG_B: begin
                w_nextState    = SY;
                w_nextDuration = {1'b0, r_tYel};
            end
            SY: begin
                w_nextState    = MG_A;
                w_nextDuration = {1'b0, r_tBase};
            end
            default: begin
                w_nextState    = MG_A;
                w_nextDuration = {1'b0, r_tBase};
            end
        endcase
    end

    always_comb begin
        led = LED_MAIN_GREEN;
        case (r_state)
            MG_A, MG_B: led = LED_MAIN_GREEN;
            MY:         led = LED_MAIN_YELLOW;
            WALK:       led = LED_WALK;
            SG_A, SG_B: led = LED_SIDE_GREEN;
            SY:         led = LED_SIDE_YELLOW;
            default:    led = LED_MAIN_GREEN;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller with one-cycle ticks.
// Expected lamp sequences are hand-built from phase lengths and compared cycle by cycle.
module tb_traffic_light_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sensor = 1'b0;
    logic       walkRequest = 1'b0;
    logic       reprogram = 1'b0;
    logic [1:0] selector = 2'b11;
    logic [3:0] timeValue = 4'd0;
    logic [6:0] led;

    int         checks = 0;
    int         errors = 0;
    logic [6:0] expQ[$];

    traffic_light_controller #(
        .TICKS_PER_SEC(1),
        .DEF_BASE     (6),
        .DEF_EXT      (3),
        .DEF_YEL      (2)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .sensor                 (sensor),
        .walk_request           (walkRequest),
        .reprogram              (reprogram),
        .time_parameter_selector(selector),
        .time_value             (timeValue),
        .led                    (led)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before the test sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic walkIn, input logic reprogIn,
                                 input logic [1:0] selIn, input logic [3:0] valueIn);
        walkRequest = walkIn;
        reprogram   = reprogIn;
        selector    = selIn;
        timeValue   = valueIn;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'b11, 4'd0);
        reset = 1'b0;
    endtask

    function automatic void addSeg(input logic [6:0] ledValue, input int count);
        for (int k = 0; k < count; k++) expQ.push_back(ledValue);
    endfunction

    task automatic test_reset();
        sensor = 1'b0;
        reset  = 1'b1;
        applyStimulus(1'b1, 1'b1, 2'b00, 4'd9);
        checks++;
        if (led !== 7'h0C) begin
            errors++;
            $display("[TB] FAIL reset_first led=%h expected=%h", led, 7'h0C);
        end
        applyStimulus(1'b1, 1'b1, 2'b00, 4'd9);
        checks++;
        if (led !== 7'h0C) begin
            errors++;
            $display("[TB] FAIL reset_held led=%h expected=%h", led, 7'h0C);
        end
        reset = 1'b0;
        expQ.delete();
        addSeg(7'h0C, 12); addSeg(7'h14, 2); addSeg(7'h21, 6); addSeg(7'h22, 2); addSeg(7'h0C, 1);
        for (int i = 1; i < expQ.size(); i++) begin
            applyStimulus(1'b0, 1'b0, 2'b11, 4'd0);
            checks++;
            if (led !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL after_reset[%0d] led=%h expected=%h", i, led, expQ[i]);
            end
        end
    endtask

    task automatic test_default_cycle();
        sensor = 1'b0;
        expQ.delete();
        for (int p = 0; p < 2; p++) begin
            addSeg(7'h0C, 12); addSeg(7'h14, 2); addSeg(7'h21, 6); addSeg(7'h22, 2);
        end
        doReset();
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) applyStimulus(1'b0, 1'b0, 2'b11, 4'd0);
            checks++;
            if (led !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL default_cycle[%0d] led=%h expected=%h", i, led, expQ[i]);
            end
        end
    endtask

    task automatic test_sensor_extension();
        sensor = 1'b1;
        expQ.delete();
        for (int p = 0; p < 2; p++) begin
            addSeg(7'h0C, 9); addSeg(7'h14, 2); addSeg(7'h21, 9); addSeg(7'h22, 2);
        end
        doReset();
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) applyStimulus(1'b0, 1'b0, 2'b11, 4'd0);
            checks++;
            if (led !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL sensor_cycle[%0d] led=%h expected=%h", i, led, expQ[i]);
            end
        end
        sensor = 1'b0;
    endtask

    task automatic test_walk_pulse();
        sensor = 1'b0;
        expQ.delete();
        addSeg(7'h0C, 12); addSeg(7'h14, 2); addSeg(7'h64, 3); addSeg(7'h21, 6); addSeg(7'h22, 2);
        addSeg(7'h0C, 12); addSeg(7'h14, 2); addSeg(7'h21, 6);
        doReset();
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) applyStimulus(i == 1, 1'b0, 2'b11, 4'd0);
            checks++;
            if (led !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL walk_pulse[%0d] led=%h expected=%h", i, led, expQ[i]);
            end
        end
    endtask

    task automatic test_walk_queue();
        sensor = 1'b0;
        expQ.delete();
        addSeg(7'h0C, 12); addSeg(7'h14, 2); addSeg(7'h64, 3); addSeg(7'h21, 6); addSeg(7'h22, 2);
        addSeg(7'h0C, 12); addSeg(7'h14, 2); addSeg(7'h64, 3); addSeg(7'h21, 6);
        doReset();
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) applyStimulus((i == 1) || (i == 15), 1'b0, 2'b11, 4'd0);
            checks++;
            if (led !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL walk_queue[%0d] led=%h expected=%h", i, led, expQ[i]);
            end
        end
    endtask

    task automatic test_walk_set_clear();
        sensor = 1'b0;
        expQ.delete();
        addSeg(7'h0C, 12); addSeg(7'h14, 2); addSeg(7'h64, 3); addSeg(7'h21, 6); addSeg(7'h22, 2);
        addSeg(7'h0C, 12); addSeg(7'h14, 2); addSeg(7'h21, 6);
        doReset();
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) applyStimulus((i == 1) || (i == 14), 1'b0, 2'b11, 4'd0);
            checks++;
            if (led !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL walk_set_clear[%0d] led=%h expected=%h", i, led, expQ[i]);
            end
        end
    endtask

    task automatic test_reprogram_base();
        sensor = 1'b0;
        doReset();
        repeat (15) applyStimulus(1'b0, 1'b0, 2'b11, 4'd0);
        checks++;
        if (led !== 7'h21) begin
            errors++;
            $display("[TB] FAIL base_pre_side_green led=%h expected=%h", led, 7'h21);
        end
        expQ.delete();
        addSeg(7'h0C, 8); addSeg(7'h14, 2); addSeg(7'h21, 4); addSeg(7'h22, 2);
        addSeg(7'h0C, 8); addSeg(7'h14, 2);
        for (int i = 0; i < expQ.size(); i++) begin
            if (i == 0) applyStimulus(1'b0, 1'b1, 2'b00, 4'd4);
            else        applyStimulus(1'b0, 1'b0, 2'b11, 4'd0);
            checks++;
            if (led !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL reprog_base[%0d] led=%h expected=%h", i, led, expQ[i]);
            end
        end
    endtask

    task automatic test_yellow_zero();
        sensor = 1'b0;
        doReset();
        applyStimulus(1'b0, 1'b0, 2'b11, 4'd0);
        expQ.delete();
        addSeg(7'h0C, 12); addSeg(7'h14, 1); addSeg(7'h21, 6); addSeg(7'h22, 1);
        addSeg(7'h0C, 12); addSeg(7'h14, 1);
        for (int i = 0; i < expQ.size(); i++) begin
            if (i == 0) applyStimulus(1'b0, 1'b1, 2'b10, 4'd0);
            else        applyStimulus(1'b0, 1'b0, 2'b11, 4'd0);
            checks++;
            if (led !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL yellow_zero[%0d] led=%h expected=%h", i, led, expQ[i]);
            end
        end
    endtask

    task automatic test_selector_none();
        sensor = 1'b0;
        expQ.delete();
        addSeg(7'h0C, 17); addSeg(7'h14, 2); addSeg(7'h64, 3); addSeg(7'h21, 6); addSeg(7'h22, 2);
        addSeg(7'h0C, 12);
        doReset();
        for (int i = 0; i < expQ.size(); i++) begin
            if (i == 5)     applyStimulus(1'b0, 1'b1, 2'b11, 4'd9);
            else if (i > 0) applyStimulus(i == 1, 1'b0, 2'b11, 4'd0);
            checks++;
            if (led !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL selector_none[%0d] led=%h expected=%h", i, led, expQ[i]);
            end
        end
    endtask

    task automatic test_reprogram_held();
        sensor = 1'b0;
        expQ.delete();
        addSeg(7'h0C, 12); addSeg(7'h14, 2); addSeg(7'h0C, 15); addSeg(7'h14, 2); addSeg(7'h21, 6);
        doReset();
        for (int i = 0; i < expQ.size(); i++) begin
            if (i >= 14 && i <= 17) applyStimulus(1'b0, 1'b1, 2'b11, 4'd0);
            else if (i > 0)         applyStimulus(1'b0, 1'b0, 2'b11, 4'd0);
            checks++;
            if (led !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL reprog_held[%0d] led=%h expected=%h", i, led, expQ[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        sensor = 1'b0;
        doReset();
        applyStimulus(1'b0, 1'b1, 2'b00, 4'd4);
        applyStimulus(1'b0, 1'b1, 2'b01, 4'd5);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'd1);
        repeat (9) applyStimulus(1'b0, 1'b0, 2'b11, 4'd0);
        checks++;
        if (led !== 7'h21) begin
            errors++;
            $display("[TB] FAIL programmed_side_green led=%h expected=%h", led, 7'h21);
        end
        sensor = 1'b1;
        expQ.delete();
        addSeg(7'h0C, 9); addSeg(7'h14, 2); addSeg(7'h21, 9); addSeg(7'h22, 2); addSeg(7'h0C, 1);
        reset = 1'b1;
        for (int i = 0; i < expQ.size(); i++) begin
            applyStimulus(1'b0, 1'b0, 2'b11, 4'd0);
            reset = 1'b0;
            checks++;
            if (led !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL reset_mid_run[%0d] led=%h expected=%h", i, led, expQ[i]);
            end
        end
        sensor = 1'b0;
    endtask

    initial begin
        $display("[TB] starting traffic_light_controller bench");
        test_reset();
        test_default_cycle();
        test_sensor_extension();
        test_walk_pulse();
        test_walk_queue();
        test_walk_set_clear();
        test_reprogram_base();
        test_yellow_zero();
        test_selector_none();
        test_reprogram_held();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
